// File: rtl/mem_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl_pkg
// Purpose  : Shared state encoding and default widths for the MEM-stage control
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_ctrl_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Wait counter is wide enough for the largest legal TIMEOUT (255)
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl_if
// Purpose  : Data-memory req/ack bus between the MEM-stage control and memory
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_ctrl_if
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl_wait_timer
// Purpose  : Access wait counter with clear/enable; flags the last allowed cycle
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl_wait_timer
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15   // legal range 1..255
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic en,
  output logic      term
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == TERM_VAL);

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : MEM-stage sequencer around a variable-latency data memory
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              mem_read,
  input  wire logic              mem_write,
  input  wire logic [ADDR_W-1:0] mem_addr,
  input  wire logic [DATA_W-1:0] mem_wdata,
  mem_stage_ctrl_if.master       dmem,
  output logic                   pipe_stall,
  output logic                   wb_bubble,
  output logic [DATA_W-1:0]      rdata_out,
  output logic                   mem_err,
  input  wire logic              err_clr
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              stall_c;
  logic              in_access;
  logic              timer_term;

  assign in_access = (state_q == ST_ACCESS);

  mem_stage_ctrl_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (!in_access),
    .en   (in_access),
    .term (timer_term)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q & ~err_clr;
    stall_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          stall_c = 1'b1;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          we_d    = mem_write;      // a write wins when both are flagged
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall_c = 1'b1;
        if (dmem.ack) begin
          if (!we_q) begin
            rdata_d = dmem.rdata;
          end
          state_d = ST_DONE;
        end else if (timer_term) begin
          rdata_d = '0;
          err_d   = 1'b1;           // timeout set beats a same-cycle clear
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Inputs ignored here so the same EX/MEM contents cannot re-trigger
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign dmem.req   = in_access;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;

  assign pipe_stall = stall_c & ~rst;
  assign wb_bubble  = stall_c & ~rst;
  assign rdata_out  = rdata_q;
  assign mem_err    = err_q;

endmodule
`default_nettype wire
